// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls in, PC and IF/ID register out.
// FETCH_PERF_EN adds the FetchCount/StallCount counter outputs.
interface instruction_fetch_unit_if;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] PCOut;
  logic [31:0] InstructionIn;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        MisalignFault;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  // No handshake: InstructionIn is the same-cycle memory response to PCOut,
  // and every IF/ID output is valid on each cycle while IFID_Valid qualifies content.
  modport master (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, InstructionIn,
    output PCOut, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignFault
`ifdef FETCH_PERF_EN
    , output FetchCount, StallCount
`endif
  );

  modport slave (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, InstructionIn,
    input  PCOut, IFID_Instruction, IFID_PCPlus4, IFID_Valid, MisalignFault
`ifdef FETCH_PERF_EN
    , input FetchCount, StallCount
`endif
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, redirect/stall/flush handling, IF/ID register.
// Optional FETCH_PERF_EN adds fetch and stall event counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input logic Clk,
  input logic Reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] LP_ADDR_MASK = 32'(IMEM_WORDS * 4 - 1);
  localparam logic [31:0] LP_WORD_MASK = LP_ADDR_MASK & ~32'h3;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        r_fault;

  logic [31:0] w_seq;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_bubble;
  logic        w_misalign;

  assign w_seq        = (r_pc + 32'd4) & LP_ADDR_MASK;
  // Branch beats jump: the branch belongs to the older instruction.
  assign w_raw_target = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
  assign w_target     = w_raw_target & LP_WORD_MASK;
  assign w_redirect   = bus.BranchTaken | bus.Jump;
  assign w_bubble     = w_redirect | bus.Flush;
  assign w_misalign   = w_redirect & (w_raw_target[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (!bus.Stall) begin
        r_pc <= w_seq;
      end

      if (w_bubble) begin
        r_ifid_instr <= NOP_WORD;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else if (!bus.Stall) begin
        r_ifid_instr <= bus.InstructionIn;
        r_ifid_pc4   <= w_seq;
        r_ifid_valid <= 1'b1;
      end

      if (w_misalign) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign bus.PCOut            = r_pc;
  assign bus.IFID_Instruction = r_ifid_instr;
  assign bus.IFID_PCPlus4     = r_ifid_pc4;
  assign bus.IFID_Valid       = r_ifid_valid;
  assign bus.MisalignFault    = r_fault;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (!w_bubble && !bus.Stall) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (!w_bubble && bus.Stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign bus.FetchCount = r_fetch_count;
  assign bus.StallCount = r_stall_count;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream fetch stage of the pipelined MIPS datapath.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned instruction word together with PC+4 into the IF/ID pipeline register.
- Handles stall from hazard detection, flush, branch redirect and jump redirect.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into the PC on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; must be a power of 2; the PC wraps modulo IMEM_WORDS*4.
- NOP_WORD, 32'h00000000, word loaded into IF/ID on a bubble (sll $0,$0,0).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Stall  in  1  hold PC and IF/ID (load-use hazard).
- Flush  in  1  squash the IF/ID contents to a bubble.
- BranchTaken  in  1  branch resolved taken this cycle.
- BranchTarget  in  32  branch destination byte address.
- Jump  in  1  jump redirect this cycle.
- JumpTarget  in  32  jump destination byte address.
- PCOut  out  32  current PC, drives the instruction memory address.
- InstructionIn  in  32  word returned by the instruction memory for PCOut (same cycle).
- IFID_Instruction  out  32  registered instruction.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real instruction.
- MisalignFault  out  1  sticky; set when a redirect target has nonzero bits [1:0].

Behaviour:
- All state updates on the rising edge of Clk; Reset is sampled on that edge.
- Reset (Reset==0): PCOut=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, MisalignFault=0. Reset asserted mid-operation overrides every other input that cycle.
- seq = (PCOut+4) & (IMEM_WORDS*4-1). Targets are masked the same way, and bits [1:0] are forced to 00.
- Next PC priority, highest first:
  - BranchTaken -> BranchTarget.
  - Jump -> JumpTarget.
  - Stall -> hold PCOut.
  - otherwise -> seq.
- A redirect overrides Stall. When BranchTaken and Jump are both high, the branch wins because it is the older instruction.
- IF/ID update priority, highest first:
  - BranchTaken or Jump or Flush -> bubble: NOP_WORD, IFID_PCPlus4=0, Valid=0.
  - Stall -> hold all three IF/ID outputs.
  - otherwise -> load InstructionIn, seq, Valid=1.
- Flush alone does not alter the PC: the PC still follows Stall and seq.
- Fetch latency: instruction at PC X appears on IFID_* one edge after PCOut==X, when there is no stall.
- Wrap-around: with IMEM_WORDS=1024 and PCOut=0xFFC, the next PC is 0x000 and IFID_PCPlus4=0x000.
- MisalignFault: set on any edge where the selected redirect target has bits [1:0]!=0. It stays set until Reset.
- The unit is fully synchronous, has no combinational path from InstructionIn to PCOut, and has no latches.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, add outputs FetchCount[31:0] and StallCount[31:0], both reset to 0.
  - FetchCount increments on each edge where IF/ID loads with Valid=1.
  - StallCount increments on each edge where Stall==1 and no redirect or Flush is active.
  - Both wrap at 2^32.
- When undefined, neither port exists and no counter logic is synthesised.

Test Plan:
- Reset, with the memory model holding word i at address 4i, run 4 cycles -> PCOut 0,4,8,12,16; IFID_Instruction = words 0..3 one cycle later; IFID_PCPlus4 = 4,8,12,16; Valid=1 from the second edge.
- Stall=1 for 2 cycles at PCOut=0x10 -> PCOut stays 0x10; IF/ID holds word at 0x0C; on release, IF/ID loads word 0x10 with PCPlus4=0x14.
- BranchTaken=1, BranchTarget=0x40, with Stall=1 and Jump=1 (JumpTarget=0x80) in the same cycle -> next PCOut=0x40; IF/ID bubble (0x00000000, Valid=0); MisalignFault stays 0.
- PCOut=0xFFC, run 2 cycles -> PCOut=0x000; IFID_PCPlus4=0x000; Valid=1.
- Jump=1, JumpTarget=0x22 -> PCOut=0x20; MisalignFault=1 and stays 1 until Reset; then Reset=0 mid-run -> all outputs return to their reset values on the next edge.
- FETCH_PERF_EN defined: 5 clean fetches, 2 stalls, 1 flush -> FetchCount=5, StallCount=2.
